// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receive end of a 4-slot time-division word link.
// Serial words arrive in slot order a, b, c, d, and slot 0 carries a start-of-frame
// flag. Each complete frame is presented on four parallel lanes with a one-cycle
// out_valid pulse.
// Optional feature: define TDM_DEMUX_ERRCNT_EN to add a saturating 8-bit framing
// error counter on port err_cnt.
module tdm_demux_4ch #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sof,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic             frame_err,
  output logic [1:0]       slot
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic             err_hit;

  // A framing violation happens only while synchronised: a missing SOF on
  // slot 0, or an SOF that arrives before the current frame is complete.
  always_comb begin
    err_hit = 1'b0;
    if (in_valid && (state == RECV)) begin
      if (slot == 2'd0) err_hit = !in_sof;
      else              err_hit = in_sof;
    end
  end

  // Frame sync FSM: collects slots 0..2 in shadow registers and publishes all
  // four lanes together when slot 3 arrives, so outputs never show a partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      slot      <= 2'd0;
      s0        <= '0;
      s1        <= '0;
      s2        <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        HUNT: begin
          // Non-SOF words are dropped silently until a frame start is seen.
          if (in_valid && in_sof) begin
            s0    <= in_data;
            slot  <= 2'd1;
            state <= RECV;
          end
        end
        RECV: begin
          if (in_valid) begin
            frame_err <= err_hit;
            if (in_sof) begin
              // A fresh SOF always restarts the frame, whether it was expected
              // (slot 0) or early (the partial frame is abandoned).
              s0   <= in_data;
              slot <= 2'd1;
            end else if (slot == 2'd0) begin
              slot  <= 2'd0;
              state <= HUNT;
            end else if (slot == 2'd3) begin
              a         <= s0;
              b         <= s1;
              c         <= s2;
              d         <= in_data;
              out_valid <= 1'b1;
              slot      <= 2'd0;
            end else begin
              if (slot == 2'd1) s1 <= in_data;
              else              s2 <= in_data;
              slot <= slot + 2'd1;
            end
          end
        end
        default: begin
          state <= HUNT;
          slot  <= 2'd0;
        end
      endcase
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) return v;
    return v + 8'd1;
  endfunction

  // Counts every framing violation, in step with the frame_err pulse it causes.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (err_hit) begin
      err_cnt <= sat_inc8(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Testbench for tdm_demux_4ch: per-cycle vector table plus a frame scoreboard.
// Define TDM_DEMUX_ERRCNT_EN to also exercise the error counter.
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_sof = 1'b0;
  logic [3:0] a, b, c, d;
  logic       out_valid, frame_err;
  logic [1:0] slot;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [15:0] last_frame = 16'h0000;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        r;
    logic        v;
    logic        s;
    logic [3:0]  dat;
    logic        ov;
    logic        fe;
    logic [1:0]  sl;
    logic [15:0] fr;
  } vec_t;

  vec_t vecs[$];

  tdm_demux_4ch #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_sof(in_sof),
    .a(a),
    .b(b),
    .c(c),
    .d(d),
    .out_valid(out_valid),
    .frame_err(frame_err),
    .slot(slot)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic v, input logic s,
                              input logic [3:0] dat, input logic ov, input logic fe,
                              input logic [1:0] sl, input logic [15:0] fr);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.dat = dat;
    t.ov = ov; t.fe = fe; t.sl = sl; t.fr = fr;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle, then check the registered outputs just after the edge.
  task automatic apply(input vec_t t);
    rst      = t.r;
    in_valid = t.v;
    in_sof   = t.s;
    in_data  = t.dat;
    if (t.ov) exp_q.push_back(t.fr);
    @(posedge clk);
    #1;
    check("out_valid", {15'd0, out_valid}, {15'd0, t.ov});
    check("frame_err", {15'd0, frame_err}, {15'd0, t.fe});
    check("slot", {14'd0, slot}, {14'd0, t.sl});
    if (t.r) begin
      last_frame = 16'h0000;
      check("reset_lanes", {a, b, c, d}, 16'h0000);
      mon_en = 1'b1;
    end
  endtask

  // Scoreboard: each out_valid pops one expected frame; otherwise lanes must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %h, expected no out_valid", {a, b, c, d});
        end else begin
          last_frame = exp_q.pop_front();
          check("frame", {a, b, c, d}, last_frame);
        end
      end else begin
        check("hold", {a, b, c, d}, last_frame);
      end
    end
  end

  initial begin
    // reset (second cycle shows rst overriding a valid SOF)
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 0, 0, 16'h0));
    vecs.push_back(mk(1, 1, 1, 4'h5, 0, 0, 0, 16'h0));
    // clean frame 0,1,2,3
    vecs.push_back(mk(0, 1, 1, 4'h0, 0, 0, 1, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h1, 0, 0, 2, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h2, 0, 0, 3, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h3, 1, 0, 0, 16'h0123));
    // gapped frame; an SOF with in_valid low is ignored
    vecs.push_back(mk(0, 1, 1, 4'h0, 0, 0, 1, 16'h0));
    vecs.push_back(mk(0, 0, 1, 4'h7, 0, 0, 1, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h1, 0, 0, 2, 16'h0));
    vecs.push_back(mk(0, 0, 0, 4'h9, 0, 0, 2, 16'h0));
    vecs.push_back(mk(0, 0, 0, 4'h9, 0, 0, 2, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h2, 0, 0, 3, 16'h0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 4'hE, 0, 0, 3, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h3, 1, 0, 0, 16'h0123));
    // back-to-back frames 4567, 89AB
    vecs.push_back(mk(0, 1, 1, 4'h4, 0, 0, 1, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h5, 0, 0, 2, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h6, 0, 0, 3, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h7, 1, 0, 0, 16'h4567));
    vecs.push_back(mk(0, 1, 1, 4'h8, 0, 0, 1, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h9, 0, 0, 2, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 0, 0, 3, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'hB, 1, 0, 0, 16'h89AB));
    // early SOF at slot 2: {1,2} dropped, then 5678
    vecs.push_back(mk(0, 1, 1, 4'h1, 0, 0, 1, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h2, 0, 0, 2, 16'h0));
    vecs.push_back(mk(0, 1, 1, 4'h5, 0, 1, 1, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h6, 0, 0, 2, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h7, 0, 0, 3, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h8, 1, 0, 0, 16'h5678));
    // early SOF at slot 3: no output for 1,2,3; then 9ABC
    vecs.push_back(mk(0, 1, 1, 4'h1, 0, 0, 1, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h2, 0, 0, 2, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h3, 0, 0, 3, 16'h0));
    vecs.push_back(mk(0, 1, 1, 4'h9, 0, 1, 1, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'hA, 0, 0, 2, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'hB, 0, 0, 3, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'hC, 1, 0, 0, 16'h9ABC));
    // missing SOF -> HUNT; later non-SOF words silent; then CDEF
    vecs.push_back(mk(0, 1, 0, 4'h9, 0, 1, 0, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h3, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h4, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 1, 1, 4'hC, 0, 0, 1, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'hD, 0, 0, 2, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'hE, 0, 0, 3, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'hF, 1, 0, 0, 16'hCDEF));
    // reset mid-frame, then HUNT ignores a non-SOF word, then clean 1234
    vecs.push_back(mk(0, 1, 1, 4'hE, 0, 0, 1, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'hF, 0, 0, 2, 16'h0));
    vecs.push_back(mk(1, 1, 0, 4'h3, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h7, 0, 0, 0, 16'h0));
    vecs.push_back(mk(0, 1, 1, 4'h1, 0, 0, 1, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h2, 0, 0, 2, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h3, 0, 0, 3, 16'h0));
    vecs.push_back(mk(0, 1, 0, 4'h4, 1, 0, 0, 16'h1234));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 16'h0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

`ifdef TDM_DEMUX_ERRCNT_EN
    apply(mk(1, 0, 0, 4'h0, 0, 0, 0, 16'h0));
    check("err_cnt_reset", {8'd0, err_cnt}, 16'd0);
    apply(mk(0, 1, 1, 4'h1, 0, 0, 1, 16'h0));
    for (int i = 0; i < 3; i++) apply(mk(0, 1, 1, 4'h2, 0, 1, 1, 16'h0));
    check("err_cnt_3", {8'd0, err_cnt}, 16'd3);
    for (int i = 0; i < 260; i++) begin
      apply(mk(0, 1, 1, 4'h2, 0, 1, 1, 16'h0));
      if (i == 251) check("err_cnt_255", {8'd0, err_cnt}, 16'd255);
    end
    check("err_cnt_sat", {8'd0, err_cnt}, 16'd255);
`endif

    @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
